multiple_fp32: RTL and testbench
================================

# multiple_fp32

Single-precision (IEEE-754 binary32) floating-point multiplier with a registered output stage. It accepts two 32-bit operands and produces their product, a done strobe and an overflow flag one clock later. It serves as the multiply unit of the FP datapath, alongside the add/subtract unit, and is driven directly from operand registers.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- n_rst  in  1  synchronous reset, active-high: asserted when 1 and sampled on the rising edge of clk. The name is kept for consistency with the codebase; the polarity is fixed.
- mul_start  in  1  request qualifier; an X/Z value is treated as 0.
- op1  in  32  operand A, binary32.
- op2  in  32  operand B, binary32.
- mul_result  out  32  registered product, binary32.
- mul_done  out  1  registered; high for the cycle after mul_start was sampled high.
- mul_overflow  out  1  registered; high when the registered product overflowed to infinity.

## Operation
- Datapath is free-running: every non-reset clock edge registers f(op1, op2) into mul_result, whether or not mul_start is asserted.
- mul_done = mul_start delayed by one register. There is no FSM and no busy state; back-to-back starts give back-to-back done pulses.
- Computation for finite, normal operands:
  - sign = s1 ^ s2.
  - Mantissas are 1.m1 × 1.m2, computed as a 24×24 → 48-bit product.
  - If product bit 47 is set, shift right by 1 and add 1 to the exponent.
  - The biased exponent is computed in a 10-bit signed intermediate: e1 + e2 − 127 (+1 after normalize).
- Rounding: see Configuration. A rounding carry-out renormalises, with exponent +1.
- Special cases, evaluated in priority order:
  - Either operand NaN (exp = 255, frac ≠ 0) → result 0x7FC00000, overflow 0.
  - Infinity × zero → result 0x7FC00000, overflow 0.
  - Either operand infinity → signed infinity, overflow 0.
  - Either exponent = 0 (zero or denormal, flushed) → signed zero.
  - Final exponent ≥ 255 → signed infinity ({sign, 8'hFF, 23'b0}), mul_overflow = 1.
  - Final exponent ≤ 0 → signed zero, mul_overflow = 0. No denormal output.
- mul_overflow is registered in the same cycle as the mul_result it describes.

## Timing
- Reset: while n_rst = 1 at a rising edge, mul_result = 0x00000000, mul_done = 0 and mul_overflow = 0. Reset has priority over all other inputs.
- Reset mid-stream: the in-flight result is discarded, and the outputs are 0 after that edge.
- Latency is 1 cycle. Operands are stable before rising edge N; the result, overflow and done are valid after edge N and held until edge N+1.
- Operands changed at a negedge are valid at the following posedge. The result can be read one full clock period after the change.
- Throughput is 1 result per cycle.
- Operand changes between edges have no effect on the outputs until the next edge.
- Inputs and outputs have no combinational path between them.

## Configuration
- MULTIPLE_RNE_EN defined: round-to-nearest-even using the guard, round and sticky bits of the discarded product bits. Rounding may itself cause overflow, which sets mul_overflow.
- MULTIPLE_RNE_EN undefined: truncate (round toward zero); the discarded bits are dropped.
- Exact products, including all the Test plan vectors except the rounding case, give identical results in both builds.

## Test plan
- Reset: n_rst = 1 for one edge → mul_result = 0x00000000, mul_done = 0, mul_overflow = 0. Deassert → normal operation.
- Positive × positive:
  - 0x3FA00000 × 0x3FC00000 (1.25 × 1.5) → 0x3FF00000 one cycle later.
  - 0x40000000 × 0x40400000 (2 × 3) → 0x40C00000.
- Mixed and negative signs:
  - 0x3F800000 × 0xC0C00000 (1 × −6) → 0xC0C00000.
  - 0xC0400000 × 0xC0800000 (−3 × −4) → 0x41400000.
- Overflow and handshake:
  - 0x7F000000 × 0x7F000000 → 0x7F800000 with mul_overflow = 1.
  - mul_start pulsed for 1 cycle → mul_done high for exactly the following cycle.
- Specials:
  - 0x00000000 × 0xC0000000 → 0x80000000.
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0x00800000 × 0x00800000 → 0x00000000 (underflow).
- Rounding: 0x3F800001 × 0x3F800001.
  - With MULTIPLE_RNE_EN → 0x3F800002.
  - Without MULTIPLE_RNE_EN → 0x3F800002 (carry bits retained), then confirm 0x3FFFFFFF × 0x3FFFFFFF gives 0x407FFFFE when truncating and 0x407FFFFE when rounding to nearest even.

Source files
------------

// File: rtl/multiple_fp32.sv
// binary32 multiplier, one registered stage, flush-to-zero on input and output.
// Define MULTIPLE_RNE_EN for round-to-nearest-even; default truncates.
module multiple_fp32 (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        mul_start,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   output logic [31:0] mul_result,
   output logic        mul_done,
   output logic        mul_overflow
);

   logic               s1, s2, sign;
   logic [7:0]         e1, e2;
   logic [22:0]        f1, f2;
   logic               nan1, nan2, inf1, inf2, zero1, zero2;
   logic [47:0]        prod, norm;
   logic signed [9:0]  exp_raw, exp_n, exp_fin;
   logic [22:0]        frac_fin;
   logic [31:0]        next_result;
   logic               next_ovf;

   assign s1    = op1[31];
   assign s2    = op2[31];
   assign e1    = op1[30:23];
   assign e2    = op2[30:23];
   assign f1    = op1[22:0];
   assign f2    = op2[22:0];
   assign sign  = s1 ^ s2;
   assign nan1  = (e1 == 8'hFF) && (f1 != 23'd0);
   assign nan2  = (e2 == 8'hFF) && (f2 != 23'd0);
   assign inf1  = (e1 == 8'hFF) && (f1 == 23'd0);
   assign inf2  = (e2 == 8'hFF) && (f2 == 23'd0);
   assign zero1 = (e1 == 8'h00);
   assign zero2 = (e2 == 8'h00);

   always_comb begin
      prod    = {24'd0, 1'b1, f1} * {24'd0, 1'b1, f2};
      exp_raw = $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127;
      if (prod[47]) begin
         norm  = prod;
         exp_n = exp_raw + 10'sd1;
      end else begin
         norm  = {prod[46:0], 1'b0};
         exp_n = exp_raw;
      end
   end

`ifdef MULTIPLE_RNE_EN
   logic        guard, rnd, sticky, rnd_up;
   logic [24:0] mant_r;

   always_comb begin
      guard   = norm[23];
      rnd     = norm[22];
      sticky  = |norm[21:0];
      rnd_up  = guard & (rnd | sticky | norm[24]);
      mant_r  = {1'b0, norm[47:24]} + {24'd0, rnd_up};
      // carry out of 1.111..1 leaves 10.000..0: renormalise
      if (mant_r[24]) begin
         frac_fin = mant_r[23:1];
         exp_fin  = exp_n + 10'sd1;
      end else begin
         frac_fin = mant_r[22:0];
         exp_fin  = exp_n;
      end
   end
`else
   logic unused_lo;

   assign unused_lo = ^{norm[47], norm[23:0]};

   always_comb begin
      frac_fin = norm[46:24];
      exp_fin  = exp_n;
   end
`endif

   always_comb begin
      next_result = 32'd0;
      next_ovf    = 1'b0;
      if (nan1 || nan2) begin
         next_result = 32'h7FC0_0000;
      end else if ((inf1 && zero2) || (inf2 && zero1)) begin
         next_result = 32'h7FC0_0000;
      end else if (inf1 || inf2) begin
         next_result = {sign, 8'hFF, 23'd0};
      end else if (zero1 || zero2) begin
         next_result = {sign, 31'd0};
      end else if (exp_fin >= 10'sd255) begin
         next_result = {sign, 8'hFF, 23'd0};
         next_ovf    = 1'b1;
      end else if (exp_fin <= 10'sd0) begin
         next_result = {sign, 31'd0};
      end else begin
         next_result = {sign, exp_fin[7:0], frac_fin};
      end
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         mul_result   <= 32'd0;
         mul_done     <= 1'b0;
         mul_overflow <= 1'b0;
      end else begin
         mul_result   <= next_result;
         mul_done     <= (mul_start === 1'b1);
         mul_overflow <= next_ovf;
      end
   end

endmodule

// File: tb/tb_multiple_fp32.sv
// Directed-vector bench for multiple_fp32.
// Expected values are hand-computed and identical for both rounding builds.
module tb_multiple_fp32;

   logic        clk;
   logic        n_rst;
   logic        mul_start;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [31:0] mul_result;
   logic        mul_done;
   logic        mul_overflow;

   int checks = 0;
   int errors = 0;

   multiple_fp32 dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .mul_start    (mul_start),
      .op1          (op1),
      .op2          (op2),
      .mul_result   (mul_result),
      .mul_done     (mul_done),
      .mul_overflow (mul_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic mul(input string tag, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp,
                      input logic ovf);
      @(negedge clk);
      op1       = a;
      op2       = b;
      mul_start = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_res"}, mul_result, exp);
      check({tag, "_ovf"}, {31'd0, mul_overflow}, {31'd0, ovf});
      check({tag, "_done"}, {31'd0, mul_done}, 32'd1);
   endtask

   initial begin
      n_rst     = 1'b1;
      mul_start = 1'b0;
      op1       = 32'h3FA0_0000;
      op2       = 32'h3FC0_0000;
      @(posedge clk);
      #1;
      check("rst_res", mul_result, 32'h0000_0000);
      check("rst_done", {31'd0, mul_done}, 32'd0);
      check("rst_ovf", {31'd0, mul_overflow}, 32'd0);
      @(negedge clk);
      n_rst = 1'b0;

      mul("p_1p25x1p5", 32'h3FA0_0000, 32'h3FC0_0000, 32'h3FF0_0000, 1'b0);
      mul("p_2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0);
      mul("m_1xn6", 32'h3F80_0000, 32'hC0C0_0000, 32'hC0C0_0000, 1'b0);
      mul("m_n3xn4", 32'hC040_0000, 32'hC080_0000, 32'h4140_0000, 1'b0);
      mul("ovf", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1);
      mul("zero_neg", 32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0);
      mul("inf_zero", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0);
      mul("nan", 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0);
      mul("inf_neg", 32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 1'b0);
      mul("underflow", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0);
      mul("rnd_a", 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0);
      mul("rnd_b", 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 1'b0);

      // single-cycle start pulse: done high one cycle then low
      @(negedge clk);
      mul_start = 1'b0;
      op1       = 32'h4000_0000;
      op2       = 32'h4000_0000;
      @(posedge clk);
      #1;
      check("done_low", {31'd0, mul_done}, 32'd0);
      check("free_run", mul_result, 32'h4080_0000);

      // reset mid-stream discards the in-flight product
      @(negedge clk);
      mul_start = 1'b1;
      op1       = 32'h4040_0000;
      op2       = 32'h4040_0000;
      n_rst     = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_res", mul_result, 32'h0000_0000);
      check("mid_rst_done", {31'd0, mul_done}, 32'd0);
      @(negedge clk);
      n_rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_res", mul_result, 32'h4110_0000);
      check("post_rst_done", {31'd0, mul_done}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
